// File: rtl/pwm_deadtime_interlock_pkg.sv
// Shared types and constants for the inverter gate dead-time interlock.
// Leg state enum, default dead time, counter width and leg indices.
package pwm_pkg;

  localparam int DT_CYC_DEF = 50;
  localparam int DT_W       = 8;

  localparam int LEG_I1_L = 0;
  localparam int LEG_I1_R = 1;
  localparam int LEG_I2_L = 2;
  localparam int LEG_I2_R = 3;

  typedef enum logic [1:0] {
    DEAD  = 2'd0,
    H_ON  = 2'd1,
    L_ON  = 2'd2,
    FAULT = 2'd3
  } leg_st_e;

endpackage

// File: rtl/pwm_deadtime_interlock_dt_leg.sv
// One half-bridge leg: dead-time FSM, saturating counter, sticky fault.
// Ports: clk_i, rst_ni (sync, active-low), h_i/l_i commands, clr_ok_i,
// force_off_i; h_o/l_o gates, flag_o fault flag, flag_d_o next flag.
module dt_leg
  import pwm_pkg::*;
#(
  parameter int DT_CYC = DT_CYC_DEF,
  parameter int CNT_W  = DT_W
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic h_i,
  input  logic l_i,
  input  logic clr_ok_i,
  input  logic force_off_i,
  output logic h_o,
  output logic l_o,
  output logic flag_o,
  output logic flag_d_o
);

  localparam logic [CNT_W-1:0] DT_MAX = CNT_W'(DT_CYC);

  leg_st_e          state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             h_q, h_d;
  logic             l_q, l_d;
  logic             flag_q, flag_d;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= DEAD;
      cnt_q   <= '0;
      h_q     <= 1'b0;
      l_q     <= 1'b0;
      flag_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      h_q     <= h_d;
      l_q     <= l_d;
      flag_q  <= flag_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    h_d     = 1'b0;
    l_d     = 1'b0;
    flag_d  = flag_q;
    if (h_i && l_i) begin
      state_d = FAULT;
      cnt_d   = '0;
      flag_d  = 1'b1;
    end else if (state_q == FAULT) begin
      // leave only once every leg is idle and clear is asserted
      if (clr_ok_i) begin
        state_d = DEAD;
        cnt_d   = '0;
        flag_d  = 1'b0;
      end
    end else if (force_off_i) begin
      // another leg is faulted: park here with dead time restarted
      state_d = DEAD;
      cnt_d   = '0;
    end else begin
      case (state_q)
        DEAD: begin
          if (cnt_q != DT_MAX) begin
            cnt_d = cnt_q + 1'b1;
          end else if (h_i) begin
            state_d = H_ON;
            h_d     = 1'b1;
          end else if (l_i) begin
            state_d = L_ON;
            l_d     = 1'b1;
          end
        end
        H_ON: begin
          if (h_i) begin
            h_d = 1'b1;
          end else begin
            state_d = DEAD;
            cnt_d   = '0;
          end
        end
        L_ON: begin
          if (l_i) begin
            l_d = 1'b1;
          end else begin
            state_d = DEAD;
            cnt_d   = '0;
          end
        end
        default: begin
          state_d = DEAD;
          cnt_d   = '0;
        end
      endcase
    end
  end

  assign h_o      = h_q;
  assign l_o      = l_q;
  assign flag_o   = flag_q;
  assign flag_d_o = flag_d;

endmodule

// File: rtl/pwm_deadtime_interlock.sv
// Dead-time inserter and shoot-through interlock for 10 gate commands.
// Ports: CLK_50M, Rst_n, 10 *_In commands, Fault_clr; 10 *_Gt, Fault_n, Fault_leg.
module pwm_deadtime_interlock #(
  parameter int DT_CYC = pwm_pkg::DT_CYC_DEF,
  parameter int DT_W   = pwm_pkg::DT_W
) (
  input  logic       CLK_50M,
  input  logic       Rst_n,
  input  logic       R_LH_In,
  input  logic       R_RH_In,
  input  logic       I1_LH_In,
  input  logic       I1_LL_In,
  input  logic       I1_RH_In,
  input  logic       I1_RL_In,
  input  logic       I2_LH_In,
  input  logic       I2_LL_In,
  input  logic       I2_RH_In,
  input  logic       I2_RL_In,
  input  logic       Fault_clr,
  output logic       R_LH_Gt,
  output logic       R_RH_Gt,
  output logic       I1_LH_Gt,
  output logic       I1_LL_Gt,
  output logic       I1_RH_Gt,
  output logic       I1_RL_Gt,
  output logic       I2_LH_Gt,
  output logic       I2_LL_Gt,
  output logic       I2_RH_Gt,
  output logic       I2_RL_Gt,
  output logic       Fault_n,
  output logic [3:0] Fault_leg
);

  import pwm_pkg::*;

  logic [3:0] h_in, l_in;
  logic [3:0] h_gt, l_gt;
  logic [3:0] flag, flag_nx;
  logic       clr_ok;
  logic       force_off;
  logic       r_lh_q, r_rh_q;
  logic       fault_n_q;

  assign h_in[LEG_I1_L] = I1_LH_In;
  assign l_in[LEG_I1_L] = I1_LL_In;
  assign h_in[LEG_I1_R] = I1_RH_In;
  assign l_in[LEG_I1_R] = I1_RL_In;
  assign h_in[LEG_I2_L] = I2_LH_In;
  assign l_in[LEG_I2_L] = I2_LL_In;
  assign h_in[LEG_I2_R] = I2_RH_In;
  assign l_in[LEG_I2_R] = I2_RL_In;

  // clearing is only honoured once no leg command is active
  assign clr_ok    = Fault_clr & ~|{h_in, l_in};
  // next-state flags so a new fault blanks every gate on the same edge
  assign force_off = |flag_nx;

  for (genvar g = 0; g < 4; g++) begin : g_leg
    dt_leg #(
      .DT_CYC (DT_CYC),
      .CNT_W  (DT_W)
    ) u_leg (
      .clk_i       (CLK_50M),
      .rst_ni      (Rst_n),
      .h_i         (h_in[g]),
      .l_i         (l_in[g]),
      .clr_ok_i    (clr_ok),
      .force_off_i (force_off),
      .h_o         (h_gt[g]),
      .l_o         (l_gt[g]),
      .flag_o      (flag[g]),
      .flag_d_o    (flag_nx[g])
    );
  end

  always_ff @(posedge CLK_50M) begin
    if (!Rst_n) begin
      r_lh_q    <= 1'b0;
      r_rh_q    <= 1'b0;
      fault_n_q <= 1'b1;
    end else begin
      r_lh_q    <= R_LH_In & ~force_off;
      r_rh_q    <= R_RH_In & ~force_off;
      fault_n_q <= ~force_off;
    end
  end

  assign R_LH_Gt   = r_lh_q;
  assign R_RH_Gt   = r_rh_q;
  assign I1_LH_Gt  = h_gt[LEG_I1_L];
  assign I1_LL_Gt  = l_gt[LEG_I1_L];
  assign I1_RH_Gt  = h_gt[LEG_I1_R];
  assign I1_RL_Gt  = l_gt[LEG_I1_R];
  assign I2_LH_Gt  = h_gt[LEG_I2_L];
  assign I2_LL_Gt  = l_gt[LEG_I2_L];
  assign I2_RH_Gt  = h_gt[LEG_I2_R];
  assign I2_RL_Gt  = l_gt[LEG_I2_R];
  assign Fault_n   = fault_n_q;
  assign Fault_leg = flag;

endmodule

// File: tb/tb_pwm_deadtime_interlock.sv
// Bench for pwm_deadtime_interlock: dead time, interlock, fault clear.
// Bit order of in_v/gt: R_LH,R_RH,I1_LH,I1_LL,I1_RH,I1_RL,I2_LH,I2_LL,I2_RH,I2_RL.
module tb_pwm_deadtime_interlock;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [9:0] in_v;
  logic       fclr;
  wire  [9:0] gt;
  wire        fault_n;
  wire  [3:0] fault_leg;

  int checks = 0;
  int errors = 0;
  int exp_q[$];

  always #10 clk = ~clk;

  pwm_deadtime_interlock dut (
    .CLK_50M   (clk),
    .Rst_n     (rst_n),
    .R_LH_In   (in_v[0]),
    .R_RH_In   (in_v[1]),
    .I1_LH_In  (in_v[2]),
    .I1_LL_In  (in_v[3]),
    .I1_RH_In  (in_v[4]),
    .I1_RL_In  (in_v[5]),
    .I2_LH_In  (in_v[6]),
    .I2_LL_In  (in_v[7]),
    .I2_RH_In  (in_v[8]),
    .I2_RL_In  (in_v[9]),
    .Fault_clr (fclr),
    .R_LH_Gt   (gt[0]),
    .R_RH_Gt   (gt[1]),
    .I1_LH_Gt  (gt[2]),
    .I1_LL_Gt  (gt[3]),
    .I1_RH_Gt  (gt[4]),
    .I1_RL_Gt  (gt[5]),
    .I2_LH_Gt  (gt[6]),
    .I2_LL_Gt  (gt[7]),
    .I2_RH_Gt  (gt[8]),
    .I2_RL_Gt  (gt[9]),
    .Fault_n   (fault_n),
    .Fault_leg (fault_leg)
  );

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    int n;
    int e;
    bit lo_bad;
    rst_n = 1'b0;
    in_v  = '0;
    fclr  = 1'b0;
    repeat (3) tick();
    checks++;
    if (gt !== 10'b0) begin
      errors++;
      $display("FAIL rst_gates got %b exp %b", gt, 10'b0);
    end
    checks++;
    if (fault_n !== 1'b1) begin
      errors++;
      $display("FAIL rst_fault_n got %b exp 1", fault_n);
    end
    checks++;
    if (fault_leg !== 4'b0) begin
      errors++;
      $display("FAIL rst_fault_leg got %b exp 0000", fault_leg);
    end
    rst_n   = 1'b1;
    in_v[2] = 1'b1;
    exp_q.push_back(51);
    n = 0;
    lo_bad = 1'b0;
    while (gt[2] !== 1'b1 && n < 200) begin
      tick();
      n++;
      if (gt[3] !== 1'b0) lo_bad = 1'b1;
    end
    e = exp_q.pop_front();
    checks++;
    if (n != e) begin
      errors++;
      $display("FAIL i1lh_turn_on got %0d cycles exp %0d", n, e);
    end
    checks++;
    if (lo_bad) begin
      errors++;
      $display("FAIL i1ll_quiet got 1 exp 0");
    end
  endtask

  task automatic test_swap();
    int n;
    int m;
    int e;
    in_v[2] = 1'b0;
    in_v[3] = 1'b1;
    exp_q.push_back(1);
    exp_q.push_back(51);
    n = 0;
    while (gt[2] !== 1'b0 && n < 10) begin
      tick();
      n++;
    end
    e = exp_q.pop_front();
    checks++;
    if (n != e) begin
      errors++;
      $display("FAIL i1lh_turn_off got %0d cycles exp %0d", n, e);
    end
    m = 0;
    while (gt[3] !== 1'b1 && m < 200) begin
      tick();
      m++;
    end
    e = exp_q.pop_front();
    checks++;
    if (m != e) begin
      errors++;
      $display("FAIL swap_dead_time got %0d cycles exp %0d", m, e);
    end
    checks++;
    if (fault_n !== 1'b1) begin
      errors++;
      $display("FAIL swap_no_fault got %b exp 1", fault_n);
    end
  endtask

  task automatic test_shoot_through();
    in_v[3] = 1'b0;
    in_v[0] = 1'b1;
    tick();
    tick();
    checks++;
    if (gt !== 10'b00_0000_0001) begin
      errors++;
      $display("FAIL pre_fault_gates got %b exp %b", gt, 10'b1);
    end
    in_v[8] = 1'b1;
    in_v[9] = 1'b1;
    tick();
    checks++;
    if (fault_leg !== 4'b1000) begin
      errors++;
      $display("FAIL st_fault_leg got %b exp 1000", fault_leg);
    end
    checks++;
    if (fault_n !== 1'b0) begin
      errors++;
      $display("FAIL st_fault_n got %b exp 0", fault_n);
    end
    checks++;
    if (gt !== 10'b0) begin
      errors++;
      $display("FAIL st_gates got %b exp %b", gt, 10'b0);
    end
    in_v[8] = 1'b0;
    in_v[9] = 1'b0;
    repeat (3) tick();
    checks++;
    if (gt !== 10'b0 || fault_leg !== 4'b1000) begin
      errors++;
      $display("FAIL st_held got %b/%b exp 0/1000", gt, fault_leg);
    end
  endtask

  task automatic test_fault_clear();
    int n;
    int e;
    in_v[8] = 1'b1;
    fclr    = 1'b1;
    repeat (3) tick();
    checks++;
    if (fault_leg !== 4'b1000 || fault_n !== 1'b0) begin
      errors++;
      $display("FAIL clr_blocked got %b/%b exp 1000/0", fault_leg, fault_n);
    end
    in_v[8] = 1'b0;
    tick();
    checks++;
    if (fault_leg !== 4'b0000 || fault_n !== 1'b1) begin
      errors++;
      $display("FAIL clr_done got %b/%b exp 0000/1", fault_leg, fault_n);
    end
    checks++;
    if (gt[0] !== 1'b1) begin
      errors++;
      $display("FAIL clr_r_lh got %b exp 1", gt[0]);
    end
    in_v[8] = 1'b1;
    exp_q.push_back(51);
    n = 0;
    while (gt[8] !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
    e = exp_q.pop_front();
    checks++;
    if (n != e) begin
      errors++;
      $display("FAIL clr_turn_on got %0d cycles exp %0d", n, e);
    end
    fclr    = 1'b0;
    in_v[8] = 1'b0;
    tick();
  endtask

  task automatic test_short_pulse();
    int n;
    int e;
    int pulses;
    bit flt;
    in_v[4] = 1'b1;
    n = 0;
    while (gt[4] !== 1'b1 && n < 60) begin
      tick();
      n++;
    end
    checks++;
    if (gt[4] !== 1'b1) begin
      errors++;
      $display("FAIL sp_rh_on got %b exp 1", gt[4]);
    end
    in_v[4] = 1'b0;
    tick();
    checks++;
    if (gt[4] !== 1'b0) begin
      errors++;
      $display("FAIL sp_rh_off got %b exp 0", gt[4]);
    end
    repeat (9) tick();
    exp_q.push_back(0);
    pulses = 0;
    flt = 1'b0;
    in_v[5] = 1'b1;
    for (int i = 0; i < 60; i++) begin
      if (i == 20) in_v[5] = 1'b0;
      tick();
      if (gt[5] !== 1'b0) pulses++;
      if (fault_n !== 1'b1) flt = 1'b1;
    end
    e = exp_q.pop_front();
    checks++;
    if (pulses != e) begin
      errors++;
      $display("FAIL sp_rl_pulse got %0d exp %0d", pulses, e);
    end
    checks++;
    if (flt) begin
      errors++;
      $display("FAIL sp_no_fault got 1 exp 0");
    end
  endtask

  task automatic test_reset_mid_on();
    int n;
    int e;
    in_v[6] = 1'b1;
    n = 0;
    while (gt[6] !== 1'b1 && n < 60) begin
      tick();
      n++;
    end
    checks++;
    if (gt[6] !== 1'b1) begin
      errors++;
      $display("FAIL rm_on got %b exp 1", gt[6]);
    end
    rst_n = 1'b0;
    tick();
    checks++;
    if (gt !== 10'b0) begin
      errors++;
      $display("FAIL rm_off got %b exp %b", gt, 10'b0);
    end
    rst_n = 1'b1;
    exp_q.push_back(51);
    n = 0;
    while (gt[6] !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
    e = exp_q.pop_front();
    checks++;
    if (n != e) begin
      errors++;
      $display("FAIL rm_turn_on got %0d cycles exp %0d", n, e);
    end
    in_v[6] = 1'b0;
    tick();
  endtask

  task automatic test_rectifier();
    logic v;
    logic e;
    in_v[0] = 1'b1;
    for (int i = 0; i < 16; i++) begin
      v = (i == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      in_v[1] = v;
      exp_q.push_back(int'(v));
      tick();
      e = 1'(exp_q.pop_front());
      checks++;
      if (gt[1] !== e) begin
        errors++;
        $display("FAIL rect_rh[%0d] got %b exp %b", i, gt[1], e);
      end
    end
    checks++;
    if (fault_n !== 1'b1 || gt[0] !== 1'b1) begin
      errors++;
      $display("FAIL rect_pair got %b/%b exp 1/1", fault_n, gt[0]);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    in_v  = '0;
    fclr  = 1'b0;
    test_reset();
    test_swap();
    test_shoot_through();
    test_fault_clear();
    test_short_pulse();
    test_reset_mid_on();
    test_rectifier();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
